if2_stage: RTL and testbench

Second instruction-fetch stage. It sits between IF1, which issues instruction-memory requests, and ID, which latches `if22id_bus` whenever `stall[2]` is low. The stage tracks outstanding fetch PCs and pairs each in-order memory response with its PC. Responses from wrong-path fetches are dropped after a branch or flush, and surviving instructions are buffered so that an ID stall never loses a response.

---
 rtl/if2_stage_pkg.sv | 32 +++
 rtl/if2_stage_if.sv | 28 ++
 rtl/if2_fifo.sv | 61 ++++++
 rtl/if2_stage.sv | 106 ++++++++++
 tb/tb_if2_stage.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/if2_stage_pkg.sv
// Shared types and widths for the second instruction-fetch stage.
// Latency: n/a (types, constants and a packing helper only).
// Backpressure: n/a.
package if2_stage_pkg;

  // Pipeline stall vector: stall[STALL_ID] high means ID is not accepting.
  localparam int STALL_W    = 6;
  localparam int STALL_ID   = 2;

  // Bus widths between IF1, IF2, EX and ID.
  localparam int IF12IF2_WD = 33;  // {pc_valid, pc[31:0]}
  localparam int IF22ID_WD  = 65;  // {inst[31:0], pc_valid, pc[31:0]}
  localparam int BR_WD      = 33;  // {br_e, br_addr[31:0]}

  // One outstanding fetch: its PC and the epoch it was issued in.
  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } pend_t;

  // One fetched instruction waiting for ID.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } obuf_t;

  // Format a buffered instruction as the ID bus word with pc_valid set.
  function automatic logic [IF22ID_WD-1:0] pack_id(input obuf_t e);
    return {e.inst, 1'b1, e.pc};
  endfunction

endpackage

// File: rtl/if2_stage_if.sv
// Signal bundle around IF2: IF1 request, imem response, EX/trap redirect, ID bus.
// Latency: n/a (wiring only).
// Backpressure: if2_allow_in gates IF1 issue; stall[STALL_ID] holds the ID bus.
interface if2_stage_if;
  import if2_stage_pkg::*;

  logic                  flush;
  logic [STALL_W-1:0]    stall;
  logic [BR_WD-1:0]      br_bus;
  logic [IF12IF2_WD-1:0] if12if2_bus;
  logic                  if2_allow_in;
  logic                  inst_rvalid;
  logic [31:0]           inst_rdata;
  logic [IF22ID_WD-1:0]  if22id_bus;

  // Surrounding pipeline / memory side.
  modport master (
    output flush, stall, br_bus, if12if2_bus, inst_rvalid, inst_rdata,
    input  if2_allow_in, if22id_bus
  );

  // The IF2 stage itself.
  modport slave (
    input  flush, stall, br_bus, if12if2_bus, inst_rvalid, inst_rdata,
    output if2_allow_in, if22id_bus
  );

endinterface

// File: rtl/if2_fifo.sv
// Generic synchronous FIFO with registered count and flop-sourced head word.
// Latency: a push is visible at head on the cycle after the write edge.
// Backpressure: none internally; a push into a full FIFO without a pop is dropped, clear wins over push/pop.
module if2_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; clear empties in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/if2_stage.sv
// IF2: pairs in-order imem responses with their PCs, drops wrong-path ones, buffers for ID.
// Latency: a response accepted at edge N is on if22id_bus after edge N.
// Backpressure: if2_allow_in drops when pending + buffered reaches DEPTH; stall[STALL_ID] holds the head.
module if2_stage
  import if2_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  if2_stage_if.slave io
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          stall_id;
  logic          br_e;
  logic          pc_valid;
  logic [31:0]   pc;
  logic          kill;
  logic          epoch;

  pend_t         pend_dat;
  pend_t         pend_head;
  logic          pend_push;
  logic          pend_pop;
  logic          pend_empty;
  logic [CW-1:0] pend_cnt;

  obuf_t         obuf_dat;
  obuf_t         obuf_head;
  logic          obuf_push;
  logic          obuf_pop;
  logic          obuf_empty;
  logic [CW-1:0] obuf_cnt;

  logic [CW:0]   credit_used;
  logic          unused_bits;

  assign stall_id = io.stall[STALL_ID];
  assign br_e     = io.br_bus[BR_WD-1];
  assign pc_valid = io.if12if2_bus[IF12IF2_WD-1];
  assign pc       = io.if12if2_bus[31:0];

  // Branch target and the other stall bits belong to other stages.
  assign unused_bits = ^{io.br_bus[31:0], io.stall[STALL_W-1:STALL_ID+1], io.stall[STALL_ID-1:0]};

  // A branch only redirects once ID actually takes it; EX holds br_e until then.
  assign kill = io.flush | (br_e & ~stall_id);

  // Epoch flips on every redirect so older in-flight fetches can be recognised as stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) epoch <= 1'b0;
    else if (kill) epoch <= ~epoch;
  end

  // Outstanding fetches, tagged with the epoch current at issue (pre-toggle on a kill cycle).
  assign pend_push      = pc_valid & io.if2_allow_in;
  assign pend_dat.pc    = pc;
  assign pend_dat.epoch = epoch;
  assign pend_pop       = io.inst_rvalid & ~pend_empty;

  if2_fifo #(
    .WIDTH ($bits(pend_t)),
    .DEPTH (DEPTH)
  ) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pend_push),
    .push_dat (pend_dat),
    .pop      (pend_pop),
    .clear    (1'b0),
    .count    (pend_cnt),
    .head     (pend_head),
    .empty    (pend_empty)
  );

  // Keep a response only if it belongs to the live path and nothing redirects this cycle.
  assign obuf_push     = pend_pop & (pend_head.epoch == epoch) & ~kill;
  assign obuf_dat.inst = io.inst_rdata;
  assign obuf_dat.pc   = pend_head.pc;
  assign obuf_pop      = ~obuf_empty & ~stall_id & ~kill;

  if2_fifo #(
    .WIDTH ($bits(obuf_t)),
    .DEPTH (DEPTH)
  ) u_obuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (obuf_push),
    .push_dat (obuf_dat),
    .pop      (obuf_pop),
    .clear    (kill),
    .count    (obuf_cnt),
    .head     (obuf_head),
    .empty    (obuf_empty)
  );

  // Stale pending entries still hold a credit, so every response in flight has a buffer slot.
  assign credit_used     = {1'b0, pend_cnt} + {1'b0, obuf_cnt};
  assign io.if2_allow_in = (credit_used < (CW+1)'(DEPTH));

  // Head of the buffer straight from flops; zero when nothing is ready.
  assign io.if22id_bus = obuf_empty ? '0 : pack_id(obuf_head);

endmodule

// File: tb/tb_if2_stage.sv
// Bench for if2_stage: directed scenarios plus random traffic against a queue-level model.
// Latency: model expects a response on the ID bus the cycle after acceptance.
// Backpressure: random stall, branch and flush; the imem model answers in order, >=1 cycle after issue.
module tb_if2_stage;
  import if2_stage_pkg::*;

  localparam int DEPTH = 4;

  typedef struct { logic [31:0] pc; bit ep; } mp_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } mb_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; int issue; } im_t;

  logic clk = 1'b0;
  logic rst_n;
  if2_stage_if io();

  if2_stage #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int delivered = 0;

  // Reference model state: pending fetches, buffered instructions, epoch, imem queue.
  mp_t m_pend[$];
  mb_t m_buf[$];
  im_t imem[$];
  bit  m_epoch;
  logic [31:0] req_inst;
  bit  stray_en = 0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every active edge: response, delivery, redirect, issue.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_pend.delete();
        m_buf.delete();
        imem.delete();
        m_epoch = 0;
      end else begin
        bit kill, credit, wr, st;
        mp_t pe;
        mb_t nb;
        st     = io.stall[STALL_ID];
        kill   = io.flush | (io.br_bus[32] & !st);
        credit = (m_pend.size() + m_buf.size()) < DEPTH;
        wr     = 0;
        if (io.inst_rvalid && m_pend.size() > 0) begin
          pe = m_pend.pop_front();
          if (pe.ep == m_epoch && !kill) begin
            wr = 1;
            nb.inst = io.inst_rdata;
            nb.pc   = pe.pc;
          end
        end
        if (m_buf.size() > 0 && !st && !kill) begin
          void'(m_buf.pop_front());
          delivered++;
        end
        if (kill) m_buf.delete();
        else if (wr) m_buf.push_back(nb);
        if (io.if12if2_bus[32] && credit) begin
          m_pend.push_back('{pc: io.if12if2_bus[31:0], ep: m_epoch});
          imem.push_back('{pc: io.if12if2_bus[31:0], inst: req_inst, issue: cyc});
        end
        if (kill) m_epoch = !m_epoch;
        cyc++;
      end
    end
  end

  // Monitor: compare the ID bus and credit against the model every cycle, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [64:0] exp_bus;
        exp_bus = '0;
        if (m_buf.size() > 0) exp_bus = {m_buf[0].inst, 1'b1, m_buf[0].pc};
        check("id_bus", io.if22id_bus, exp_bus);
        check("allow_in", 65'(io.if2_allow_in), 65'((m_pend.size() + m_buf.size()) < DEPTH));
      end
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic step(input bit pv, input logic [31:0] pc, input logic [31:0] ins,
                      input bit rsp, input bit st, input bit br, input bit fl);
    io.if12if2_bus = {pv, pc};
    req_inst       = ins;
    io.stall       = st ? 6'b000100 : 6'b000000;
    io.br_bus      = {br, 32'h8000_0100};
    io.flush       = fl;
    io.inst_rvalid = 1'b0;
    io.inst_rdata  = 32'h0;
    if (rsp && imem.size() > 0 && imem[0].issue < cyc) begin
      io.inst_rvalid = 1'b1;
      io.inst_rdata  = imem[0].inst;
      void'(imem.pop_front());
    end else if (rsp && imem.size() == 0 && stray_en && ($urandom % 8 == 0)) begin
      io.inst_rvalid = 1'b1;
      io.inst_rdata  = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rsp, input bit st);
    for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, rsp, st, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    rst_n = 1'b0;
    io.if12if2_bus = '0; io.stall = '0; io.br_bus = '0; io.flush = 0;
    io.inst_rvalid = 0; io.inst_rdata = '0; req_inst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_bus", io.if22id_bus, 65'h0);
    check("reset_allow", 65'(io.if2_allow_in), 65'd1);
    @(posedge clk); #1;

    // Streaming: each instruction one cycle after its response.
    step(1, 32'h8000_0000, 32'h0000_0013, 1, 0, 0, 0);
    step(1, 32'h8000_0004, 32'h0010_0093, 1, 0, 0, 0);
    check("stream0", io.if22id_bus, {32'h0000_0013, 1'b1, 32'h8000_0000});
    step(1, 32'h8000_0008, 32'h0020_0113, 1, 0, 0, 0);
    check("stream1", io.if22id_bus, {32'h0010_0093, 1'b1, 32'h8000_0004});
    step(0, 32'h0, 32'h0, 1, 0, 0, 0);
    check("stream2", io.if22id_bus, {32'h0020_0113, 1'b1, 32'h8000_0008});
    idle(3, 1, 0);

    // Backpressure: four issues under stall fill the credit; a fifth is refused.
    for (int i = 0; i < 4; i++) step(1, 32'h8000_0040 + 32'(4*i), 32'h1000_0000 + 32'(i), 1, 1, 0, 0);
    check("bp_allow_low", 65'(io.if2_allow_in), 65'd0);
    for (int i = 0; i < 4; i++) step(1, 32'h8000_0050, 32'hdead_0005, 1, 1, 0, 0);
    check("bp_allow_held", 65'(io.if2_allow_in), 65'd0);
    check("bp_head", io.if22id_bus, {32'h1000_0000, 1'b1, 32'h8000_0040});
    idle(6, 1, 0);

    // Branch kill with two fetches outstanding, then a new-path fetch.
    step(1, 32'h8000_0080, 32'h2000_0000, 0, 0, 0, 0);
    step(1, 32'h8000_0084, 32'h2000_0001, 0, 0, 0, 0);
    step(0, 32'h0, 32'h0, 0, 0, 1, 0);
    step(1, 32'h8000_0100, 32'h2000_0100, 1, 0, 0, 0);
    idle(5, 1, 0);

    // Branch under stall is not a redirect.
    step(1, 32'h8000_0200, 32'h3000_0000, 0, 1, 0, 0);
    step(1, 32'h8000_0204, 32'h3000_0001, 1, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 1, 0, 0);
    step(0, 32'h0, 32'h0, 0, 1, 1, 0);
    check("br_stall_keep", io.if22id_bus, {32'h3000_0000, 1'b1, 32'h8000_0200});
    idle(4, 1, 0);

    // Flush with three buffered and one pending; the stale response is not delivered.
    for (int i = 0; i < 4; i++) step(1, 32'h8000_0300 + 32'(4*i), 32'h4000_0000 + 32'(i), i > 0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 0, 1, 0, 1);
    check("flush_bus0", io.if22id_bus, 65'h0);
    idle(3, 1, 0);
    step(1, 32'h8000_0400, 32'h5000_0000, 1, 0, 0, 0);
    idle(3, 1, 0);

    // Async reset between edges mid-stream.
    step(1, 32'h8000_0500, 32'h6000_0000, 1, 1, 0, 0);
    step(1, 32'h8000_0504, 32'h6000_0001, 1, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bus", io.if22id_bus, 65'h0);
    check("arst_allow", 65'(io.if2_allow_in), 65'd1);
    io.inst_rvalid = 0; io.if12if2_bus = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random traffic.
    stray_en = 1;
    pc = 32'h9000_0000;
    for (int i = 0; i < 2000; i++) begin
      bit pv;
      pv = ($urandom % 3) != 0;
      step(pv, pc, $urandom, ($urandom % 4) != 0, ($urandom % 4) == 0,
           ($urandom % 20) == 0, ($urandom % 40) == 0);
      if (pv) pc = pc + 32'd4;
    end
    stray_en = 0;
    idle(12, 1, 0);
    check("drained_bus", io.if22id_bus, 65'h0);
    check("drained_allow", 65'(io.if2_allow_in), 65'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
